// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit teaching CPU.
// Control strobes are a combinational decode of the registered phase, the opcode and zero.
package typedefs;
    typedef enum logic [2:0] {HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP} opcode_t;
endpackage

module cpu_controller
    import typedefs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    input  logic       zero,
    output logic [2:0] phase,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       halt,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr
);
    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } phase_t;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // HLT parks the sequencer in OP_ADDR; only reset releases it.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == HLT) halted_d = 1'b1;
            else                                     phase_d  = phase_t'(phase_q + 3'd1);
        end
    end

    assign aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
    assign phase = phase_q;

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR:  ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

    a_phase_step: assert property (@(posedge clk) disable iff (rst)
        (!halted_q && !(phase_q == OP_ADDR && opcode == HLT))
        |=> (phase_q == phase_t'($past(phase_q) + 3'd1)));

    a_wr_only_sto: assert property (@(posedge clk) disable iff (rst)
        mem_wr |-> (opcode == STO && phase_q == STORE));

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst)
        !(mem_rd && mem_wr));
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction sequencer for the 8-bit teaching CPU.
- Drives every load, strobe and memory-control line of the datapath.
- Sits directly upstream of the ALU and accumulator; ALU output is consumed via load_ac, and the ALU zero flag feeds back into this block.
- Steps a fixed 8-phase cycle per instruction, advancing on posedge clk. The ALU evaluates on negedge, so ALU results are settled by the next controller edge.

Parameters:
- None. Opcode width is fixed by typedefs::opcode_t (3 bits; HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP).

Ports:
- clk  input  1  system clock; state advances on posedge.
- rst  input  1  reset, asynchronous, active-high.
- opcode  input  opcode_t(3)  current instruction opcode from the instruction register.
- zero  input  1  accumulator-zero flag from the ALU.
- phase  output  3  current phase encoding, for debug and bench observation.
- mem_rd  output  1  memory read enable.
- load_ir  output  1  load instruction register.
- halt  output  1  CPU halted.
- inc_pc  output  1  increment program counter.
- load_ac  output  1  load accumulator from ALU out.
- load_pc  output  1  load program counter from operand address.
- mem_wr  output  1  memory write enable.

Behaviour:
- Phase state register, encodings 0..7 in this order: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- The phase output equals the encoding of the current phase.
- Each posedge advances one phase; STORE wraps to INST_ADDR. One instruction takes exactly 8 clocks.
- rst high: phase goes to INST_ADDR immediately (asynchronous), the halted flag clears, and all control outputs are 0.
- While rst is held, no advance. Reset asserted mid-instruction aborts that instruction; no partial strobe may persist.
- Control outputs are combinational decode of the registered phase, opcode and zero, so they are valid for the whole phase.
- ALUOP means opcode is ADD, AND, XOR or LDA.
- Decode per phase (outputs not listed are 0):
  - INST_ADDR: all outputs 0.
  - INST_FETCH: mem_rd=1.
  - INST_LOAD: mem_rd=1, load_ir=1.
  - IDLE: mem_rd=1, load_ir=1.
  - OP_ADDR: inc_pc=1; halt=(opcode==HLT).
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==JMP), load_pc=(opcode==JMP), mem_wr=(opcode==STO).
- Halt:
  - At a posedge while in OP_ADDR with opcode==HLT, a halted flag sets and the phase stays at OP_ADDR.
  - While halted: halt=1, all other outputs 0 (inc_pc suppressed), and the phase frozen.
  - Only rst clears the halted flag.
- mem_rd and mem_wr are never both 1 in the same phase.
- zero is sampled only in ALU_OP; toggling it in any other phase has no effect.
- Opcode changes outside IDLE, OP_ADDR, OP_FETCH, ALU_OP and STORE do not affect outputs.
- No X on any output after reset.
- Assertions:
  - The phase always advances by exactly +1 mod 8 unless halted or in reset.
  - mem_wr implies opcode==STO and phase==STORE.

Test Plan:
- Reset: assert rst mid-clock with phase=5 -> phase=0 and all outputs 0 with no clock edge; release, then 8 clocks -> phase sequence 0,1,2,3,4,5,6,7,0.
- ADD instruction (opcode=ADD, zero=0) -> mem_rd=1 in phases 1,2,3,5,6,7; load_ir=1 in phases 2,3; inc_pc=1 only in phase 4; load_ac=1 in phases 6,7; mem_wr and load_pc never asserted.
- SKZ: zero=1 -> inc_pc=1 in phases 4 and 6; repeat with zero=0 -> inc_pc=1 only in phase 4; zero toggled in phase 5 has no effect on outputs.
- JMP -> load_pc=1 in phases 6,7; inc_pc=1 in phases 4,7; mem_rd=0 in phases 5,6,7.
- STO -> mem_wr=1 only in phase 7; mem_rd=0 in phases 5,6,7; load_ac never asserted.
- HLT -> halt=1 from phase 4; phase stays 4 for 20 further clocks with inc_pc=0; assert rst -> halt=0 and phase=0; next instruction sequences normally.
